seg_decoder_capture: RTL and testbench
======================================

SEG_DECODER_CAPTURE -- requirements
Module: seg_decoder_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 2..15: count of consecutive identical samples required before a display pattern is accepted.
REQ-002 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 seg_led_1  input  9  tens-digit pattern; bit order MSB..LSB = DIG, DP, G, F, E, D, C, B, A.
REQ-005 seg_led_2  input  9  ones-digit pattern; same bit order as seg_led_1.
REQ-006 digit_tens  output  4  accepted tens digit, BCD 0..5.
REQ-007 digit_ones  output  4  accepted ones digit, BCD 0..9.
REQ-008 value  output  6  accepted value, 0..59, equal to 10*digit_tens + digit_ones.
REQ-009 value_valid  output  1  level; high while a legal value is held.
REQ-010 change_pulse  output  1  one-cycle pulse when the accepted value differs from the previously held value, or on the first acceptance after reset or blank.
REQ-011 code_err  output  1  one-cycle pulse when a stable pattern pair is illegal.
REQ-012 err_count  output  8  count of code_err pulses since reset; saturates at 255.

Function
REQ-013 Both inputs SHALL be registered once (sample stage) before any comparison.
REQ-014 Stability counter: clears when the sampled pair differs from the previous sample; otherwise increments, saturating at STABLE_CYCLES.
REQ-015 Evaluation occurs exactly once per stable run. Condition: N=STABLE_CYCLES equal samples on edges k..k+N-1. Results SHALL register on edge k+N; no re-evaluation until the sampled pair changes.
REQ-016 Legal digit patterns: DIG=0, DP=0, and bits [6:0] equal to one of 3f,06,5b,4f,66,6d,7d,07,7f,6f, mapping to 0..9.
REQ-017 Pair legality: both patterns legal and tens digit <= 5; any other non-blank pair is illegal.
REQ-018 Blank: both inputs 9'h000 is blank, not an error.
REQ-019 State machine states:
- NOVAL: reset/blank state.
- VALID.
REQ-020 Transitions:
- legal evaluation -> VALID, load digits and value;
- blank evaluation -> NOVAL;
- illegal evaluation -> remain in the current state, outputs held.
REQ-021 change_pulse SHALL assert on a legal evaluation when the state was NOVAL or the new value differs from the held value. A legal re-evaluation of an equal value (after a glitch) SHALL NOT pulse.
REQ-022 code_err and the err_count increment SHALL occur on the same edge as the illegal evaluation; err_count holds at 255.
REQ-023 Wrap-around has no special handling: 59 -> 00 and 00 -> 59 are ordinary legal changes and SHALL pulse change_pulse.
REQ-024 Pulses and digit/value outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-025 Reset values:
- state NOVAL;
- digit_tens, digit_ones, value, err_count = 0;
- value_valid, change_pulse, code_err = 0;
- stability counter and sample registers = 0.
REQ-026 Reset asserted mid-stable-run SHALL discard the run. A pattern held across reset release SHALL need a full STABLE_CYCLES run before acceptance.
REQ-027 Reset SHALL take precedence over any simultaneous evaluation.

Structure
REQ-028 Shared package SHALL hold:
- the ten 7-segment pattern constants, shared with the existing display encoder;
- the blank constant 9'h000;
- the maximum value constant 59.
REQ-029 One sub-module, seg7_digit_decode: combinational pattern -> {legal, bcd[3:0]}, instantiated twice.

Verification
REQ-030 Basic decode: seg_led_1=9'h5b, seg_led_2=9'h6f held 6 cycles -> after 4+1 edges value=29, digits 2/9, value_valid=1, change_pulse exactly once.
REQ-031 Glitch rejection: 29 held; seg_led_2=9'h06 for 2 cycles then back to 9'h6f -> no change_pulse, no code_err, value stays 29.
REQ-032 Illegal pattern: seg_led_1=9'h66 (tens 4), seg_led_2=9'h7e held -> one code_err pulse, err_count=1, outputs unchanged. Then 9'h17f,9'h3f (DIG set) -> err_count=2.
REQ-033 Wrap: value 59 (9'h6d,9'h6f), then 00 (9'h3f,9'h3f) held -> value=0, change_pulse once. Tens 6 (9'h7d,9'h3f) -> code_err.
REQ-034 Blank and reset:
- blank pair held -> value_valid=0, no code_err;
- then 9'h06,9'h3f -> value=10, change_pulse;
- rst pulsed at sample 2 of a run -> all outputs 0 and a fresh 4-sample run is required;
- 300 illegal evaluations -> err_count=255.

Source files
------------

// File: rtl/seg_decoder_capture_pkg.sv
// seg_decoder_capture_pkg: 7-segment pattern constants and capture FSM types.
package seg_decoder_capture_pkg;

    localparam logic [6:0] SEG_0 = 7'h3f;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5b;
    localparam logic [6:0] SEG_3 = 7'h4f;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6d;
    localparam logic [6:0] SEG_6 = 7'h7d;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7f;
    localparam logic [6:0] SEG_9 = 7'h6f;

    localparam logic [6:0] SEG_TABLE [10] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4,
                                              SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};

    localparam logic [8:0] SEG_BLANK = 9'h000;
    localparam logic [5:0] MAX_VALUE = 6'd59;

    typedef enum logic {NOVAL, VALID} state_t;

endpackage

// File: rtl/seg_decoder_capture_digit_decode.sv
// seg7_digit_decode: maps a DIG/DP/segment pattern to {legal, bcd}.
module seg7_digit_decode
    import seg_decoder_capture_pkg::*;
(
    input  logic [8:0] pattern,
    output logic       legal,
    output logic [3:0] bcd
);

    logic hit;

    always_comb begin
        hit = 1'b0;
        bcd = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (pattern[6:0] == SEG_TABLE[i]) begin
                hit = 1'b1;
                bcd = 4'(i);
            end
        end
        legal = hit && pattern[8:7] == 2'b00;
    end

endmodule

// File: rtl/seg_decoder_capture.sv
// seg_decoder_capture: debounces two 7-segment digit patterns and captures a 0..59 value.
module seg_decoder_capture
    import seg_decoder_capture_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] seg_led_1,
    input  logic [8:0] seg_led_2,
    output logic [3:0] digit_tens,
    output logic [3:0] digit_ones,
    output logic [5:0] value,
    output logic       value_valid,
    output logic       change_pulse,
    output logic       code_err,
    output logic [7:0] err_count
);

    logic [8:0] samp_1, samp_2, prev_1, prev_2;
    logic [3:0] stable_cnt;
    logic       legal_t, legal_o;
    logic [3:0] bcd_t, bcd_o;
    logic [6:0] raw;
    logic       same, eval, blank, legal_pair, accept, reject;
    state_t     state, state_next;

    seg7_digit_decode u_tens (.pattern(samp_1), .legal(legal_t), .bcd(bcd_t));
    seg7_digit_decode u_ones (.pattern(samp_2), .legal(legal_o), .bcd(bcd_o));

    // stable_cnt trails the sample pipe by one edge, so the run completes when the
    // newest sample matches and the counter has seen STABLE_CYCLES-2 matching pairs
    assign same       = {samp_1, samp_2} == {prev_1, prev_2};
    assign eval       = same && stable_cnt == 4'(STABLE_CYCLES - 2);
    assign blank      = samp_1 == SEG_BLANK && samp_2 == SEG_BLANK;
    assign raw        = 7'(bcd_t) * 7'd10 + 7'(bcd_o);
    assign legal_pair = legal_t && legal_o && raw <= 7'(MAX_VALUE);
    assign accept     = eval && !blank && legal_pair;
    assign reject     = eval && !blank && !legal_pair;
    assign value_valid = state == VALID;

    always_comb begin
        state_next = state;
        if (eval && blank)
            state_next = NOVAL;
        else if (accept)
            state_next = VALID;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_1       <= '0;
            samp_2       <= '0;
            prev_1       <= '0;
            prev_2       <= '0;
            stable_cnt   <= '0;
            state        <= NOVAL;
            digit_tens   <= '0;
            digit_ones   <= '0;
            value        <= '0;
            change_pulse <= 1'b0;
            code_err     <= 1'b0;
            err_count    <= '0;
        end else begin
            samp_1       <= seg_led_1;
            samp_2       <= seg_led_2;
            prev_1       <= samp_1;
            prev_2       <= samp_2;
            stable_cnt   <= !same ? 4'd0 : stable_cnt == 4'(STABLE_CYCLES) ? stable_cnt : stable_cnt + 4'd1;
            state        <= state_next;
            change_pulse <= accept && (state == NOVAL || raw[5:0] != value);
            code_err     <= reject;
            if (accept) begin
                digit_tens <= bcd_t;
                digit_ones <= bcd_o;
                value      <= raw[5:0];
            end
            if (reject && err_count != 8'hff)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_seg_decoder_capture.sv
// tb_seg_decoder_capture: directed checks of debounce, decode, errors, wrap, blank and reset.
module tb_seg_decoder_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] seg_led_1 = '0;
    logic [8:0] seg_led_2 = '0;
    logic [3:0] digit_tens, digit_ones;
    logic [5:0] value;
    logic       value_valid, change_pulse, code_err;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;
    int chg_seen = 0;
    int err_seen = 0;
    int chg_base, err_base;

    seg_decoder_capture #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .seg_led_1(seg_led_1), .seg_led_2(seg_led_2),
        .digit_tens(digit_tens), .digit_ones(digit_ones), .value(value),
        .value_valid(value_valid), .change_pulse(change_pulse),
        .code_err(code_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (change_pulse) chg_seen++;
        if (code_err) err_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic hold(input logic [8:0] p1, input logic [8:0] p2, input int n);
        seg_led_1 = p1;
        seg_led_2 = p2;
        repeat (n) @(negedge clk);
    endtask

    task automatic mark();
        chg_base = chg_seen;
        err_base = err_seen;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_value", value, 0);
        check("rst_valid", value_valid, 0);
        check("rst_err_count", err_count, 0);
        check("rst_pulses", {change_pulse, code_err}, 0);
        rst = 1'b0;
        hold(9'h000, 9'h000, 6);

        mark();
        hold(9'h05b, 9'h06f, 4);
        check("basic_early_valid", value_valid, 0);
        hold(9'h05b, 9'h06f, 1);
        check("basic_value", value, 29);
        check("basic_tens", digit_tens, 2);
        check("basic_ones", digit_ones, 9);
        check("basic_valid", value_valid, 1);
        hold(9'h05b, 9'h06f, 3);
        check("basic_chg_once", chg_seen - chg_base, 1);

        mark();
        hold(9'h05b, 9'h006, 2);
        hold(9'h05b, 9'h06f, 6);
        check("glitch_value", value, 29);
        check("glitch_no_chg", chg_seen - chg_base, 0);
        check("glitch_no_err", err_seen - err_base, 0);

        mark();
        hold(9'h066, 9'h07e, 6);
        check("illegal_err_pulse", err_seen - err_base, 1);
        check("illegal_err_count", err_count, 1);
        check("illegal_value_held", value, 29);
        check("illegal_valid_held", value_valid, 1);
        hold(9'h17f, 9'h03f, 6);
        check("dig_set_err_count", err_count, 2);

        mark();
        hold(9'h06d, 9'h06f, 6);
        check("wrap_59", value, 59);
        hold(9'h03f, 9'h03f, 6);
        check("wrap_00", value, 0);
        check("wrap_valid", value_valid, 1);
        check("wrap_chg_count", chg_seen - chg_base, 2);
        hold(9'h07d, 9'h03f, 6);
        check("tens6_err_count", err_count, 3);
        check("tens6_value_held", value, 0);

        mark();
        hold(9'h000, 9'h000, 6);
        check("blank_valid", value_valid, 0);
        check("blank_no_err", err_seen - err_base, 0);
        hold(9'h006, 9'h03f, 6);
        check("after_blank_value", value, 10);
        check("after_blank_tens", digit_tens, 1);
        check("after_blank_chg", chg_seen - chg_base, 1);

        hold(9'h04f, 9'h066, 2);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_rst_value", value, 0);
        check("midrun_rst_valid", value_valid, 0);
        check("midrun_rst_err_count", err_count, 0);
        check("midrun_rst_digits", {digit_tens, digit_ones}, 0);
        rst = 1'b0;
        hold(9'h04f, 9'h066, 4);
        check("post_rst_early_valid", value_valid, 0);
        hold(9'h04f, 9'h066, 1);
        check("post_rst_value", value, 34);
        check("post_rst_valid", value_valid, 1);

        for (int i = 0; i < 150; i++) begin
            hold(9'h07d, 9'h03f, 5);
            hold(9'h066, 9'h07e, 5);
            if (i == 126) check("err_count_254", err_count, 254);
        end
        check("err_count_sat", err_count, 255);
        check("sat_value_held", value, 34);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
